// File: rtl/height_history_vga.sv
// Height history display: keeps the last DEPTH heights and converts each one to
// BCD with a sequential double-dabble. The digits are drawn as NDIGITS glyphs per
// row through a two-stage registered pixel pipeline.
module height_history_vga #(
    parameter int          DEPTH       = 10,
    parameter int          VAL_W       = 8,
    parameter int          NDIGITS     = 3,
    parameter int          START_X     = 50,
    parameter int          START_Y     = 50,
    parameter int          ROW_HEIGHT  = 40,
    parameter int          DIGIT_PITCH = 20,
    parameter logic [5:0]  FG_RGB      = 6'h00,
    parameter logic [5:0]  BG_RGB      = 6'h3F,
    localparam int         CNT_W       = $clog2(DEPTH + 1),
    localparam int         IDX_W       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             meas_valid,
    input  logic [VAL_W-1:0] meas_value,
    output logic             meas_ready,
    input  logic             clear,
    output logic [CNT_W-1:0] hist_count,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [VAL_W-1:0] rd_value,
    input  logic [9:0]       Row,
    input  logic [9:0]       Col,
    input  logic             valid,
    output logic [5:0]       rgb_out
);

    localparam int BCD_W = 4 * NDIGITS;
    localparam int CC_W  = $clog2(VAL_W + 1);
    localparam int DIG_W = $clog2(NDIGITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam longint unsigned MAXV = pow10(NDIGITS) - 1;

    // Glyph row for one decimal digit. Each glyph is built from seven segments
    // (a..g = bits 6..0); bit 7 of the returned byte is the leftmost column.
    // Rows 0 and 15 and column 7 stay dark so neighbouring glyphs never touch.
    function automatic logic [7:0] font_row(input logic [3:0] dig, input logic [3:0] gy);
        logic [6:0] seg;
        logic [7:0] row;
        case (dig)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
        row = 8'h00;
        if (gy == 4'd1 || gy == 4'd2) begin
            row = seg[6] ? 8'b0111_1100 : 8'h00;
        end else if (gy >= 4'd3 && gy <= 4'd6) begin
            row = (seg[1] ? 8'b1100_0000 : 8'h00) | (seg[5] ? 8'b0000_0110 : 8'h00);
        end else if (gy == 4'd7 || gy == 4'd8) begin
            row = seg[0] ? 8'b0111_1100 : 8'h00;
        end else if (gy >= 4'd9 && gy <= 4'd12) begin
            row = (seg[2] ? 8'b1100_0000 : 8'h00) | (seg[4] ? 8'b0000_0110 : 8'h00);
        end else if (gy == 4'd13 || gy == 4'd14) begin
            row = seg[3] ? 8'b0111_1100 : 8'h00;
        end
        return row;
    endfunction

    typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_COMMIT} state_t;

    state_t           r_state;
    logic [CC_W-1:0]  r_cnt;
    logic [VAL_W-1:0] r_bin;
    logic [VAL_W-1:0] r_val;
    logic [BCD_W-1:0] r_bcd;
    logic [CNT_W-1:0] r_hist_count;
    logic [BCD_W-1:0] r_ent_bcd [DEPTH];
    logic [VAL_W-1:0] r_ent_val [DEPTH];
    logic [VAL_W-1:0] r_rd_value;

    logic [VAL_W-1:0] w_clamped;
    logic [BCD_W-1:0] w_bcd_adj;
    logic [BCD_W-1:0] w_bcd_shift;

    assign meas_ready = (r_state == ST_IDLE) && !clear;
    assign hist_count = r_hist_count;
    assign rd_value   = r_rd_value;

    // Clamp values that cannot be shown in NDIGITS decimal digits to all nines.
    always_comb begin
        w_clamped = meas_value;
        if (64'(meas_value) > MAXV) begin
            w_clamped = VAL_W'(MAXV);
        end
    end

    // Double-dabble step: add 3 to every BCD digit of 5 or more before the shift.
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_adj
        assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                      r_bcd[4*gi +: 4] + 4'd3 : r_bcd[4*gi +: 4];
    end
    assign w_bcd_shift = {w_bcd_adj[BCD_W-2:0], r_bin[VAL_W-1]};

    // Acceptance / conversion / commit sequencer; clear aborts it at any point.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_bin        <= '0;
            r_val        <= '0;
            r_bcd        <= '0;
            r_hist_count <= '0;
        end else if (clear) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_hist_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (meas_valid) begin
                        r_state <= ST_CONVERT;
                        r_bin   <= w_clamped;
                        r_val   <= w_clamped;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                    end
                end
                ST_CONVERT: begin
                    r_bcd <= w_bcd_shift;
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CC_W'(VAL_W - 1)) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_state <= ST_IDLE;
                    if (r_hist_count != CNT_W'(DEPTH)) begin
                        r_hist_count <= r_hist_count + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // History shift register: a commit pushes the new entry in at index 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent_bcd[i] <= '0;
                r_ent_val[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent_bcd[i] <= '0;
                r_ent_val[i] <= '0;
            end
        end else if (r_state == ST_COMMIT) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_ent_bcd[i] <= r_ent_bcd[i-1];
                r_ent_val[i] <= r_ent_val[i-1];
            end
            r_ent_bcd[0] <= r_bcd;
            r_ent_val[0] <= r_val;
        end
    end

    // Debug readback of one stored (clamped) value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_value <= '0;
        end else begin
            r_rd_value <= (rd_idx <= LAST_IDX) ? r_ent_val[rd_idx] : '0;
        end
    end

    // ---------------- pixel pipeline ----------------
    logic [9:0] w_dy, w_dx, w_r, w_d, w_ly, w_lx;
    logic       w_in_cell;

    assign w_dy = Row - 10'(START_Y);
    assign w_dx = Col - 10'(START_X);
    assign w_r  = w_dy / 10'(ROW_HEIGHT);
    assign w_ly = w_dy % 10'(ROW_HEIGHT);
    assign w_d  = w_dx / 10'(DIGIT_PITCH);
    assign w_lx = w_dx % 10'(DIGIT_PITCH);
    assign w_in_cell = (Row >= 10'(START_Y)) && (Col >= 10'(START_X)) &&
                       (w_r < 10'(r_hist_count)) && (w_d < 10'(NDIGITS)) &&
                       (w_lx < 10'd16) && (w_ly < 10'd32);

    logic             r_s1_valid;
    logic             r_s1_in;
    logic [IDX_W-1:0] r_s1_r;
    logic [DIG_W-1:0] r_s1_d;
    logic [3:0]       r_s1_gy;
    logic [2:0]       r_s1_gx;

    // Stage 1: locate the pixel within the row/digit grid (glyphs drawn at 2x).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_in    <= 1'b0;
            r_s1_r     <= '0;
            r_s1_d     <= '0;
            r_s1_gy    <= '0;
            r_s1_gx    <= '0;
        end else begin
            r_s1_valid <= valid;
            r_s1_in    <= w_in_cell;
            r_s1_r     <= w_r[IDX_W-1:0];
            r_s1_d     <= w_d[DIG_W-1:0];
            r_s1_gy    <= w_ly[4:1];
            r_s1_gx    <= w_lx[3:1];
        end
    end

    logic [BCD_W-1:0] w_sel_bcd;
    logic [3:0]       w_dig_arr [NDIGITS];
    logic [NDIGITS-1:0] w_lead_zero;
    logic [3:0]       w_digit;
    logic             w_blank;
    logic [7:0]       w_font;
    logic             w_pix;

    assign w_sel_bcd = (r_s1_r <= LAST_IDX) ? r_ent_bcd[r_s1_r] : '0;

    // Digit 0 is the most significant; w_lead_zero[k] means digits 0..k are all zero.
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_dig
        assign w_dig_arr[gi]   = w_sel_bcd[4*(NDIGITS-1-gi) +: 4];
        assign w_lead_zero[gi] = (w_sel_bcd[BCD_W-1 -: 4*(gi+1)] == '0);
    end

    // Pick the addressed digit; leading zeros blank but the ones digit always shows.
    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b1;
        for (int k = 0; k < NDIGITS; k++) begin
            if (r_s1_d == DIG_W'(k)) begin
                w_digit = w_dig_arr[k];
                w_blank = w_lead_zero[k] && (k != NDIGITS - 1);
            end
        end
    end

    assign w_font = font_row(w_digit, r_s1_gy);
    assign w_pix  = w_font[3'd7 - r_s1_gx];

    logic [5:0] r_rgb;
    assign rgb_out = r_rgb;

    // Stage 2: font lookup and colour selection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb <= 6'h00;
        end else if (!r_s1_valid) begin
            r_rgb <= 6'h00;
        end else if (r_s1_in && !w_blank && w_pix) begin
            r_rgb <= FG_RGB;
        end else begin
            r_rgb <= BG_RGB;
        end
    end

endmodule

// File: tb/tb_height_history_vga.sv
// Bench for height_history_vga: directed scenarios plus randomized traffic, checked
// every cycle against a value-level model of the history and the rendered screen.
module tb_height_history_vga;

    localparam int DEPTH = 10;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, meas_valid, meas_ready, clear, valid;
    logic [7:0] meas_value, rd_value;
    logic [3:0] hist_count, rd_idx;
    logic [9:0] Row, Col;
    logic [5:0] rgb_out;

    logic       mv2, mrdy2, clr2, vld2;
    logic [7:0] mval2, rv2;
    logic [3:0] hc2, ri2;
    logic [9:0] row2, col2;
    logic [5:0] rgb2;

    height_history_vga u_dut (
        .clk(clk), .reset_n(reset_n), .meas_valid(meas_valid), .meas_value(meas_value),
        .meas_ready(meas_ready), .clear(clear), .hist_count(hist_count), .rd_idx(rd_idx),
        .rd_value(rd_value), .Row(Row), .Col(Col), .valid(valid), .rgb_out(rgb_out)
    );

    height_history_vga #(.NDIGITS(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .meas_valid(mv2), .meas_value(mval2),
        .meas_ready(mrdy2), .clear(clr2), .hist_count(hc2), .rd_idx(ri2),
        .rd_value(rv2), .Row(row2), .Col(col2), .valid(vld2), .rgb_out(rgb2)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Segment masks {a,b,c,d,e,f,g} for the digits 0..9 of a seven-segment face.
    int seg_m [10] = '{'h7E, 'h30, 'h6D, 'h79, 'h33, 'h5B, 'h5F, 'h70, 'h7F, 'h7B};

    function automatic bit inrect(int x, int y, int x0, int x1, int y0, int y1);
        return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
    endfunction

    // Is glyph pixel (x,y) of the 8x16 cell inside a lit segment of the digit?
    function automatic bit seg_pixel(int dig, int x, int y);
        int m;
        m = seg_m[dig];
        return (m[6] && inrect(x, y, 1, 5, 1, 2))  || (m[5] && inrect(x, y, 5, 6, 3, 6))  ||
               (m[4] && inrect(x, y, 5, 6, 9, 12)) || (m[3] && inrect(x, y, 1, 5, 13, 14)) ||
               (m[2] && inrect(x, y, 0, 1, 9, 12)) || (m[1] && inrect(x, y, 0, 1, 3, 6))  ||
               (m[0] && inrect(x, y, 1, 5, 7, 8));
    endfunction

    int m_vals [DEPTH];
    int m_cnt, m_busy, m_pend;
    // Per-cycle snapshots: index 0 = this cycle, 1 = one cycle ago, 2 = two ago.
    int s_cnt [3];
    int s_vals [3][DEPTH];
    int s_row [3], s_col [3], s_rdidx [3];
    bit s_vld [3];

    // Expected colour for a pixel presented two cycles ago, using the history
    // contents of the previous cycle and the entry count of the presentation cycle.
    function automatic int exp_pix(int row, int col, bit vld, int cnt);
        int dy, dx, r, d, lx, ly, v, p;
        if (!vld) return 0;
        if (row < 50 || col < 50) return 'h3F;
        dy = row - 50; dx = col - 50;
        r = dy / 40; d = dx / 20; ly = dy % 40; lx = dx % 20;
        if (r >= cnt || d >= 3 || lx >= 16 || ly >= 32) return 'h3F;
        v = s_vals[1][r];
        p = 10 ** (2 - d);
        if (d < 2 && v < p) return 'h3F;
        return seg_pixel((v / p) % 10, lx / 2, ly / 2) ? 'h00 : 'h3F;
    endfunction

    // Per-cycle compare against the model, then advance the model to the next edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            m_cnt = 0; m_busy = 0; m_pend = 0;
            for (int i = 0; i < DEPTH; i++) m_vals[i] = 0;
            for (int k = 0; k < 3; k++) begin
                s_cnt[k] = 0; s_row[k] = 0; s_col[k] = 0; s_rdidx[k] = 0; s_vld[k] = 0;
                for (int i = 0; i < DEPTH; i++) s_vals[k][i] = 0;
            end
        end else begin
            for (int k = 2; k > 0; k--) begin
                s_cnt[k] = s_cnt[k-1]; s_row[k] = s_row[k-1]; s_col[k] = s_col[k-1];
                s_rdidx[k] = s_rdidx[k-1]; s_vld[k] = s_vld[k-1];
                for (int i = 0; i < DEPTH; i++) s_vals[k][i] = s_vals[k-1][i];
            end
            s_cnt[0] = m_cnt; s_row[0] = Row; s_col[0] = Col; s_rdidx[0] = rd_idx; s_vld[0] = valid;
            for (int i = 0; i < DEPTH; i++) s_vals[0][i] = m_vals[i];

            check("meas_ready", meas_ready, (m_busy == 0 && !clear) ? 1 : 0);
            check("hist_count", hist_count, m_cnt);
            check("rd_value", rd_value, s_vals[1][s_rdidx[1]]);
            check("rgb_out", rgb_out, exp_pix(s_row[2], s_col[2], s_vld[2], s_cnt[2]));

            if (clear) begin
                m_busy = 0; m_cnt = 0;
                for (int i = 0; i < DEPTH; i++) m_vals[i] = 0;
            end else if (m_busy == 0) begin
                if (meas_valid) begin
                    m_busy = 9;
                    m_pend = (meas_value > 999) ? 999 : int'(meas_value);
                end
            end else begin
                m_busy--;
                if (m_busy == 0) begin
                    for (int i = DEPTH - 1; i > 0; i--) m_vals[i] = m_vals[i-1];
                    m_vals[0] = m_pend;
                    if (m_cnt < DEPTH) m_cnt++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready();
        bit ok;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (meas_ready) begin ok = 1; break; end
        end
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ready_timeout: meas_ready stayed 0, required 1 within 30 cycles");
        end
    endtask

    task automatic push(input int v);
        @(posedge clk); #1 meas_valid = 1'b1; meas_value = 8'(v);
        @(posedge clk); #1 meas_valid = 1'b0;
        wait_ready();
    endtask

    task automatic pix(input string name, input int r, input int c, input bit v, input int exp);
        @(posedge clk); #1 Row = 10'(r); Col = 10'(c); valid = v;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check(name, rgb_out, exp);
    endtask

    task automatic read_idx(input string name, input int idx, input int exp);
        @(posedge clk); #1 rd_idx = 4'(idx);
        @(posedge clk);
        @(negedge clk);
        check(name, rd_value, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lowcnt;
        reset_n = 0; meas_valid = 0; meas_value = 0; clear = 0; rd_idx = 0;
        Row = 0; Col = 0; valid = 0;
        mv2 = 0; mval2 = 0; clr2 = 0; ri2 = 0; row2 = 0; col2 = 0; vld2 = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        @(negedge clk);
        check("reset_hist_count", hist_count, 0);
        check("reset_rd_value", rd_value, 0);
        check("reset_rgb", rgb_out, 0);
        check("reset_ready", meas_ready, 1);

        // Single value with meas_valid held until the handshake.
        @(posedge clk); #1 meas_valid = 1; meas_value = 8'd123;
        @(posedge clk); #1 meas_valid = 0;
        lowcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (meas_ready) break;
            lowcnt++;
        end
        check("ready_low_cycles", lowcnt, 9);
        check("count_after_123", hist_count, 1);
        read_idx("rd_123", 0, 123);

        // Overfill the history: 12 more pushes, oldest drop out.
        for (int v = 1; v <= 12; v++) push(v);
        check("count_saturated", hist_count, 10);
        for (int i = 0; i < 10; i++) read_idx("rd_history", i, 12 - i);

        // Rendering of a single-digit value.
        @(posedge clk); #1 clear = 1;
        @(posedge clk); #1 clear = 0;
        push(7);
        pix("pix_blank_tens", 51, 51 + 20, 1, 'h3F);
        pix("pix_blank_hundreds", 51, 51, 1, 'h3F);
        pix("pix_ones_topbar", 52, 92, 1, 'h00);
        pix("pix_ones_bottom_unlit", 76, 94, 1, 'h3F);
        pix("pix_not_visible", 52, 92, 0, 'h00);
        pix("pix_row_beyond_count", 92, 92, 1, 'h3F);

        // Clear in the middle of a conversion.
        @(posedge clk); #1 meas_valid = 1; meas_value = 8'd200;
        @(posedge clk); #1 meas_valid = 0;
        repeat (3) @(posedge clk);
        #1 clear = 1;
        @(posedge clk); #1 clear = 0;
        @(negedge clk);
        check("ready_after_clear", meas_ready, 1);
        check("count_after_clear", hist_count, 0);
        repeat (12) @(negedge clk);
        check("no_commit_after_clear", hist_count, 0);
        read_idx("entry0_cleared", 0, 0);

        // Clear together with meas_valid: no acceptance.
        @(posedge clk); #1 clear = 1; meas_valid = 1; meas_value = 8'd55;
        @(negedge clk);
        check("ready_during_clear", meas_ready, 0);
        @(posedge clk); #1 clear = 0; meas_valid = 0;
        @(negedge clk);
        check("ready_after_clear_valid", meas_ready, 1);
        repeat (12) @(negedge clk);
        check("count_clear_valid", hist_count, 0);

        // Randomized traffic, checked by the per-cycle model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            valid      = ($urandom_range(0, 3) != 0);
            Row        = 10'($urandom_range(30, 520));
            Col        = 10'($urandom_range(30, 130));
            rd_idx     = 4'($urandom_range(0, 9));
            meas_valid = ($urandom_range(0, 3) == 0);
            meas_value = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom_range(0, 255));
            clear      = ($urandom_range(0, 99) == 0);
        end
        @(posedge clk); #1 meas_valid = 0; clear = 0;
        wait_ready();

        // Reset in the middle of a conversion while pixels are being drawn.
        push(42);
        @(posedge clk); #1 meas_valid = 1; meas_value = 8'd99; Row = 10'd51; Col = 10'd51; valid = 1;
        @(posedge clk); #1 meas_valid = 0;
        @(posedge clk);
        @(negedge clk);
        check("rgb_before_reset", rgb_out, 'h3F);
        @(posedge clk); #2 reset_n = 0;
        #1;
        check("rgb_async_reset", rgb_out, 0);
        check("count_async_reset", hist_count, 0);
        check("rd_async_reset", rd_value, 0);
        @(posedge clk); #1 reset_n = 1;
        @(negedge clk);
        check("ready_after_reset", meas_ready, 1);
        check("count_after_reset", hist_count, 0);
        repeat (4) @(negedge clk);

        // Two-digit variant: 255 clamps to 99 and two glyphs are drawn.
        @(posedge clk); #1 mv2 = 1; mval2 = 8'd255;
        @(posedge clk); #1 mv2 = 0;
        repeat (12) @(posedge clk);
        #1 row2 = 10'd52; col2 = 10'd52; vld2 = 1; ri2 = 0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("nd2_rd_clamped", rv2, 99);
        check("nd2_count", hc2, 1);
        check("nd2_tens_glyph", rgb2, 'h00);
        @(posedge clk); #1 col2 = 10'd72;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("nd2_ones_glyph", rgb2, 'h00);
        @(posedge clk); #1 col2 = 10'd92;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("nd2_third_cell_bg", rgb2, 'h3F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
